// File: rtl/int2float_pkg.sv
// int2float_pkg
//   Shared constants and helpers for the integer-to-float converter:
//   default field widths, exponent bias, controller state encoding and
//   the bit offsets of the float fields inside the packed result word.
//   No ports (package).
package int2float_pkg;

   localparam int E_BIT_DEF     = 8;
   localparam int F_BIT_DEF     = 23;
   localparam int INT_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   // Exponent bias for an e_bits-wide exponent field.
   function automatic int bias(input int e_bits);
      return (1 << (e_bits - 1)) - 1;
   endfunction

   // Field offsets inside {sign, exponent, fraction}.
   function automatic int frac_lsb();
      return 0;
   endfunction

   function automatic int exp_lsb(input int f_bits);
      return f_bits;
   endfunction

   function automatic int sign_pos(input int e_bits, input int f_bits);
      return e_bits + f_bits;
   endfunction

endpackage

// File: rtl/int2float_if.sv
// int2float_if
//   Handshake bundle between an integer producer, the converter and a
//   float consumer.
//   int_in/in_valid/in_ready     : operand channel (producer -> converter)
//   float_out/out_valid/out_ready: result channel  (converter -> consumer)
//   master modport: the producer/consumer side (testbench or datapath).
//   slave  modport: the converter.
interface int2float_if
   import int2float_pkg::*;
#(
   parameter int INT_WIDTH = INT_WIDTH_DEF,
   parameter int FLOAT_W   = E_BIT_DEF + F_BIT_DEF + 1
) ();

   logic [INT_WIDTH-1:0] int_in;
   logic                 in_valid;
   logic                 in_ready;
   logic [FLOAT_W-1:0]   float_out;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output int_in, in_valid, out_ready,
      input  in_ready, float_out, out_valid
   );

   modport slave (
      input  int_in, in_valid, out_ready,
      output in_ready, float_out, out_valid
   );

endinterface

// File: rtl/int2float_round.sv
// int2float_round
//   Combinational exponent/fraction generation from a normalised magnitude.
//   mag_frac : normalised magnitude without its leading 1 (bits below the MSB)
//   count    : number of left shifts applied during normalisation
//   exp_o    : biased exponent, including any mantissa carry-out
//   frac_o   : stored fraction
//   Build option INT2FLOAT_RNE_EN: defined -> round-to-nearest-even,
//   undefined -> truncate the magnitude toward zero.
module int2float_round
   import int2float_pkg::*;
#(
   parameter int E_bit     = E_BIT_DEF,
   parameter int F_bit     = F_BIT_DEF,
   parameter int INT_WIDTH = INT_WIDTH_DEF,
   parameter int CNT_W     = 6
) (
   input  logic [INT_WIDTH-2:0] mag_frac,
   input  logic [CNT_W-1:0]     count,
   output logic [E_bit-1:0]     exp_o,
   output logic [F_bit-1:0]     frac_o
);

   // Two extra zero bits keep guard and sticky in range even when the
   // integer is narrower than the fraction (then they are simply zero).
   localparam int EXP_TOP = bias(E_bit) + INT_WIDTH - 1;
   localparam int EXT_W   = INT_WIDTH - 1 + F_bit + 2;

`ifdef INT2FLOAT_RNE_EN
   localparam bit RNE_EN = 1'b1;
`else
   localparam bit RNE_EN = 1'b0;
`endif

   logic [EXT_W-1:0] ext_s;
   logic [F_bit-1:0] frac_raw_s;
   logic             guard_s;
   logic             sticky_s;
   logic             inc_s;
   logic [F_bit:0]   frac_sum_s;
   logic [E_bit-1:0] exp_base_s;

   assign ext_s      = {mag_frac, {(F_bit + 2){1'b0}}};
   assign frac_raw_s = ext_s[EXT_W-1 -: F_bit];
   assign guard_s    = ext_s[EXT_W-1-F_bit];
   assign sticky_s   = |ext_s[EXT_W-2-F_bit:0];
   // Nearest-even: bump on more than half, or exactly half with odd lsb.
   assign inc_s      = RNE_EN & guard_s & (sticky_s | frac_raw_s[0]);
   assign frac_sum_s = {1'b0, frac_raw_s} + {{F_bit{1'b0}}, inc_s};
   assign exp_base_s = E_bit'(EXP_TOP) - E_bit'(count);

   // Mantissa carry-out renormalises to fraction 0 with the next exponent.
   always_comb begin
      exp_o  = exp_base_s;
      frac_o = frac_sum_s[F_bit-1:0];
      if (frac_sum_s[F_bit]) begin
         exp_o  = exp_base_s + {{(E_bit - 1){1'b0}}, 1'b1};
         frac_o = {F_bit{1'b0}};
      end else begin
         exp_o  = exp_base_s;
         frac_o = frac_sum_s[F_bit-1:0];
      end
   end

endmodule

// File: rtl/int2float.sv
// int2float
//   Iterative signed-integer to float converter, one normalisation shift
//   per cycle, with valid/ready handshakes on both sides.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : int2float_if.slave (int_in/in_valid/in_ready,
//           float_out/out_valid/out_ready)
//   Build option INT2FLOAT_RNE_EN selects round-to-nearest-even instead
//   of truncation (handled inside int2float_round).
module int2float
   import int2float_pkg::*;
#(
   parameter int E_bit     = E_BIT_DEF,
   parameter int F_bit     = F_BIT_DEF,
   parameter int INT_WIDTH = INT_WIDTH_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   int2float_if.slave  bus
);

   localparam int FW    = E_bit + F_bit + 1;
   localparam int CNT_W = $clog2(INT_WIDTH) + 1;

   state_e               state_q, state_d;
   logic [INT_WIDTH-1:0] mag_q, mag_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 sign_q, sign_d;
   logic                 zero_q, zero_d;
   logic [FW-1:0]        float_q, float_d;
   logic                 out_valid_q, out_valid_d;
   logic [E_bit-1:0]     exp_s;
   logic [F_bit-1:0]     frac_s;
   logic                 norm_done_s;

   assign norm_done_s = zero_q | mag_q[INT_WIDTH-1];

   int2float_round #(
      .E_bit     (E_bit),
      .F_bit     (F_bit),
      .INT_WIDTH (INT_WIDTH),
      .CNT_W     (CNT_W)
   ) u_round (
      .mag_frac (mag_q[INT_WIDTH-2:0]),
      .count    (count_q),
      .exp_o    (exp_s),
      .frac_o   (frac_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.in_valid)  state_d = ST_NORM;  else state_d = ST_IDLE;
         ST_NORM:  if (norm_done_s)   state_d = ST_ROUND; else state_d = ST_NORM;
         ST_ROUND: state_d = ST_OUT;
         ST_OUT:   if (bus.out_ready) state_d = ST_IDLE;  else state_d = ST_OUT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next values per state.
   always_comb begin
      mag_d       = mag_q;
      count_d     = count_q;
      sign_d      = sign_q;
      zero_d      = zero_q;
      float_d     = float_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               sign_d  = bus.int_in[INT_WIDTH-1];
               // Two's-complement negate; the most-negative value maps to 2^(N-1).
               mag_d   = bus.int_in[INT_WIDTH-1] ?
                         (~bus.int_in + {{(INT_WIDTH - 1){1'b0}}, 1'b1}) : bus.int_in;
               zero_d  = (bus.int_in == {INT_WIDTH{1'b0}});
               count_d = {CNT_W{1'b0}};
            end else begin
               mag_d = mag_q;
            end
         end
         ST_NORM: begin
            if (!norm_done_s) begin
               mag_d   = {mag_q[INT_WIDTH-2:0], 1'b0};
               count_d = count_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            end else begin
               mag_d = mag_q;
            end
         end
         ST_ROUND: begin
            if (zero_q) begin
               float_d = {FW{1'b0}};
            end else begin
               float_d[sign_pos(E_bit, F_bit)]      = sign_q;
               float_d[exp_lsb(F_bit) +: E_bit]     = exp_s;
               float_d[frac_lsb() +: F_bit]         = frac_s;
            end
            out_valid_d = 1'b1;
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
            end else begin
               out_valid_d = out_valid_q;
            end
         end
         default: begin
            out_valid_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_q       <= {INT_WIDTH{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         sign_q      <= 1'b0;
         zero_q      <= 1'b0;
         float_q     <= {FW{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         mag_q       <= mag_d;
         count_q     <= count_d;
         sign_q      <= sign_d;
         zero_q      <= zero_d;
         float_q     <= float_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.float_out = float_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_int2float.sv
// tb_int2float
//   Directed and randomised checks of int2float (32-bit int -> binary32)
//   against an arithmetic reference model, including latency, backpressure
//   and mid-conversion reset.
module tb_int2float;

   logic clk;
   logic rst_n;
   int   checks;
   int   fails;

   int2float_if #(.INT_WIDTH(32), .FLOAT_W(32)) bus ();

   int2float dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Position of the highest set bit of |v| (v nonzero).
   function automatic int msb_pos(input logic [31:0] v);
      longint sv;
      longint unsigned m;
      int p;
      sv = longint'($signed(v));
      m  = (sv < 0) ? longint'(-sv) : longint'(sv);
      p  = 0;
      for (int i = 0; i < 64; i++) if (m[i]) p = i;
      return p;
   endfunction

   // Reference conversion: value = 2^p * (1 + f/2^23), rounded per build.
   function automatic logic [31:0] ref_float(input logic [31:0] v);
      longint sv;
      longint unsigned m, rest, f;
      int p, e, d;
      logic s;
      if (v == 32'd0) return 32'd0;
      s    = v[31];
      sv   = longint'($signed(v));
      m    = s ? longint'(-sv) : longint'(sv);
      p    = msb_pos(v);
      e    = 127 + p;
      rest = m - (64'd1 << p);
      if (p <= 23) begin
         f = rest << (23 - p);
      end else begin
         d = p - 23;
         f = rest >> d;
`ifdef INT2FLOAT_RNE_EN
         begin
            longint unsigned rem, half;
            rem  = rest & ((64'd1 << d) - 64'd1);
            half = 64'd1 << (d - 1);
            if (rem > half || (rem == half && f[0])) f = f + 64'd1;
         end
`endif
      end
      if (f == (64'd1 << 23)) begin
         f = 64'd0;
         e = e + 1;
      end
      return {s, 8'(e), 23'(f)};
   endfunction

   function automatic int ref_lat(input logic [31:0] v);
      if (v == 32'd0) return 2;
      return (31 - msb_pos(v)) + 2;
   endfunction

   // Send one operand; returns the result word and edges from capture to out_valid.
   task automatic convert(input logic [31:0] v, output logic [31:0] res, output int lat);
      int wait_n;
      wait_n = 0;
      while (!bus.in_ready && wait_n < 200) begin
         @(posedge clk); #1;
         wait_n++;
      end
      bus.int_in   = v;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = bus.float_out;
   endtask

   task automatic run_one(input logic [31:0] v);
      logic [31:0] res;
      int lat;
      convert(v, res, lat);
      check($sformatf("value_%08h", v), res, ref_float(v));
      check($sformatf("latency_%08h", v), 32'(lat), 32'(ref_lat(v)));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] dir [8];
      logic [31:0] v, res, frozen;
      int lat, seen;

      checks = 0;
      fails  = 0;
      clk = 1'b0;
      rst_n = 1'b0;
      bus.int_in = 32'd0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;

      #12;
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_float_out", bus.float_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      dir = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
              32'd16777219, 32'd16777217, 32'h7FFF_FFFF, 32'd5};
      foreach (dir[i]) run_one(dir[i]);

      for (int i = 0; i < 40; i++) begin
         v = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) v = -v;
         run_one(v);
      end

      // Backpressure: result must hold while the consumer stalls.
      bus.out_ready = 1'b0;
      convert(32'h0000_1234, res, lat);
      check("bp_value", res, ref_float(32'h0000_1234));
      frozen = res;
      for (int i = 0; i < 10; i++) begin
         bus.int_in   = $urandom;
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check("bp_float_hold", bus.float_out, frozen);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_drain_in_ready", 32'(bus.in_ready), 32'd1);
      check("bp_drain_out_valid", 32'(bus.out_valid), 32'd0);
      run_one(32'hFFFF_0000);

      // Reset in the middle of normalisation abandons the conversion.
      bus.int_in   = 32'd5;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_float_out", bus.float_out, 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      check("rst_no_output", 32'(seen), 32'd0);
      convert(32'd5, res, lat);
      check("rst_then_5", res, 32'h40A0_0000);
      check("rst_then_5_latency", 32'(lat), 32'd31);
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
